// File: rtl/sram_arbiter_pkg.sv
// Shared types and encodings for the two-master sram-like bus arbiter.
// Command packing: {wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]}.
package sram_arbiter_pkg;

  localparam int SRAM_CMD_LEN = 71;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } grant_e;

endpackage

// File: rtl/sram_arbiter_src_fifo.sv
// One-bit synchronous FIFO recording which master issued each accepted request.
// Pointers wrap naturally because DEPTH is a power of two.
module src_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_din,
  input  logic                     i_pop,
  output logic                     o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CAP);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master / one-slave arbiter for the sram-like bus (fetch vs. data).
// Responses are routed back in issue order using a source-tag FIFO.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int MAX_STREAK  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inst_req,
  input  logic [SRAM_CMD_LEN-1:0]       inst_cmd,
  output logic                          inst_addr_ok,
  output logic                          inst_data_ok,
  output logic [31:0]                   inst_rdata,
  input  logic                          data_req,
  input  logic [SRAM_CMD_LEN-1:0]       data_cmd,
  output logic                          data_addr_ok,
  output logic                          data_data_ok,
  output logic [31:0]                   data_rdata,
  output logic                          m_req,
  output logic [SRAM_CMD_LEN-1:0]       m_cmd,
  input  logic                          m_addr_ok,
  input  logic                          m_data_ok,
  input  logic [31:0]                   m_rdata,
  output logic [$clog2(OUTSTANDING):0]  outstanding,
  output logic                          err_spurious
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(MAX_STREAK);

  grant_e          r_state;
  grant_e          w_state_nx;
  logic [SW-1:0]   r_streak;
  logic            r_err;
  logic            w_grant_d;
  logic            w_accept;
  logic            w_full;
  logic            w_empty;
  logic            w_head;

  always_comb begin
    w_state_nx = r_state;
    w_grant_d  = 1'b0;
    m_req      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_full) begin
          if (data_req && !(inst_req && r_streak >= STREAK_SAT)) begin
            m_req     = 1'b1;
            w_grant_d = 1'b1;
          end else if (inst_req) begin
            m_req = 1'b1;
          end
          if (m_req && !m_addr_ok) begin
            w_state_nx = w_grant_d ? HOLD_D : HOLD_I;
          end
        end
      end
      HOLD_I: begin
        m_req = inst_req;
        if (!inst_req || m_addr_ok) w_state_nx = IDLE;
      end
      HOLD_D: begin
        m_req     = data_req;
        w_grant_d = 1'b1;
        if (!data_req || m_addr_ok) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign m_cmd        = w_grant_d ? data_cmd : inst_cmd;
  assign w_accept     = m_req & m_addr_ok;
  assign inst_addr_ok = w_accept & ~w_grant_d;
  assign data_addr_ok = w_accept & w_grant_d;

  src_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_src_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_din   (w_grant_d ? SRC_DATA : SRC_INST),
    .i_pop   (m_data_ok),
    .o_head  (w_head),
    .o_count (outstanding),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign inst_data_ok = m_data_ok & ~w_empty & (w_head == SRC_INST);
  assign data_data_ok = m_data_ok & ~w_empty & (w_head == SRC_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign err_spurious = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (m_data_ok && w_empty) r_err <= 1'b1;
      // Streak only grows while fetch is actually being starved.
      if (inst_addr_ok) begin
        r_streak <= '0;
      end else if (data_addr_ok) begin
        if (!inst_req) r_streak <= '0;
        else if (r_streak < STREAK_SAT) r_streak <= r_streak + 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-master, one-slave arbiter for the sram-like bus (req/addr_ok/data_ok).
- Shares one memory port between instruction fetch (IF stage) and data access (EXE issues, MEM consumes).
- Tracks outstanding requests in issue order and routes each data_ok/rdata back to the requester that issued it.
- Sits between the pipeline's fetch/data request logic and the single memory bridge.

Parameters:
- OUTSTANDING, 4: max accepted-but-unanswered requests (power of 2, ≥2).
- MAX_STREAK, 4: consecutive data grants allowed while inst waits before inst gets priority once.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- inst_req  in  1  fetch request valid.
- inst_cmd  in  `SRAM_CMD_LEN (71)  {wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]}.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch response valid.
- inst_rdata  out  32  fetch response data.
- data_req  in  1  data request valid.
- data_cmd  in  `SRAM_CMD_LEN  same packing as inst_cmd.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data response valid (reads and writes).
- data_rdata  out  32  data response data.
- m_req  out  1  request to the shared slave.
- m_cmd  out  `SRAM_CMD_LEN  command of the granted master.
- m_addr_ok  in  1  slave accepts request.
- m_data_ok  in  1  slave response valid, strictly in order.
- m_rdata  in  32  slave response data.
- outstanding  out  $clog2(OUTSTANDING)+1  current outstanding count.
- err_spurious  out  1  sticky: m_data_ok seen with no outstanding request.

Behaviour:
- Reset: lock state IDLE, FIFO empty, outstanding=0, streak=0, err_spurious=0. All outputs are combinational from this state, so m_req=0 and all *_addr_ok/*_data_ok=0 while no input is active.
- full = (outstanding == OUTSTANDING). While full, m_req=0 and no addr_ok is issued. A same-cycle pop does not lift this block; full is a registered-count decision.
- Grant FSM, states IDLE / HOLD_I / HOLD_D:
  - IDLE, not full: pick winner. Data wins if data_req and not (inst_req and streak ≥ MAX_STREAK); otherwise inst wins if inst_req.
  - m_req=1 and m_cmd = winner's cmd.
  - If m_addr_ok: accept, stay IDLE. Otherwise go to HOLD_I or HOLD_D.
- HOLD_x: grant is pinned to x, so the bus never switches requester with req pending. Return to IDLE on m_addr_ok. Masters keep req/cmd stable until addr_ok, per sram-like rules.
- Accept = m_req & m_addr_ok. Only the granted master's addr_ok equals accept, in the same cycle, with no added latency.
- Streak counter:
  - Data accept while inst_req=1: streak++, saturating at MAX_STREAK.
  - Any inst accept: streak=0.
  - Data accept with inst_req=0: streak=0.
- Source FIFO: depth OUTSTANDING, 1-bit entry (SRC_INST/SRC_DATA).
  - Push on accept; pop on m_data_ok when non-empty.
  - Push and pop in the same cycle: count unchanged, pointers both advance, with wrap-around modulo OUTSTANDING.
- Response routing, combinational, zero latency:
  - inst_data_ok = m_data_ok & !empty & head==SRC_INST. data_data_ok likewise for SRC_DATA.
  - Both rdata outputs = m_rdata (consumers qualify with their data_ok).
- m_data_ok while empty: no data_ok to either master, err_spurious←1 until reset.
- Writes occupy a FIFO slot and receive data_ok like reads.
- Reset mid-operation discards the FIFO. Any slave responses arriving afterwards are spurious and set err_spurious. The system must reset the bridge together with this block.

Decomposition:
- Add to macros.h: `SRAM_CMD_LEN, SRC_INST/SRC_DATA encodings, and grant state encodings (IDLE=2'd0, HOLD_I=2'd1, HOLD_D=2'd2).
- Sub-module src_fifo: parameterised 1-bit sync FIFO with push, pop, head, count, full, empty, and async active-high reset.
- The arbiter top holds the FSM, streak counter and routing.

Test Plan:
- Single inst read; addr_ok same cycle; data_ok 2 cycles later with rdata=0x1234_5678 -> inst_addr_ok pulse, then inst_data_ok=1 with inst_rdata=0x12345678; data_data_ok stays 0.
- Both req every cycle, slave always ready, MAX_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I…
- Inst wins, m_addr_ok held low 3 cycles while data_req rises -> FSM in HOLD_I, m_cmd stays inst_cmd for all 3 cycles, and data is granted only after inst accept.
- Issue 4 requests with no data_ok -> outstanding=4, m_req=0 on the 5th. Then m_data_ok and a new req in the same cycle -> no accept that cycle; accept next cycle; outstanding reads 3 then 4.
- Order I,D,I,D accepted; 4 data_ok pulses -> routed inst,data,inst,data; FIFO wraps with outstanding=0 at end, err_spurious=0.
- m_data_ok with empty FIFO -> no *_data_ok, err_spurious=1 and held. Then assert reset mid-burst with 2 outstanding -> outstanding=0 and err_spurious=0 immediately, asynchronously.
